// File: rtl/fir_filter_seq.sv
// Signed FIR filter that runs one multiply-accumulate per clock over a runtime-writable
// coefficient bank, with valid/ready handshakes on the sample input and the result output.
module fir_filter_seq #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned COEF_W = 9,
    parameter int unsigned N_TAPS = 8,
    parameter int unsigned OUT_W  = 9,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_W-1:0]    in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]    coef_wdata,
    output logic signed [OUT_W-1:0]     out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int unsigned K_W    = $clog2(N_TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = DATA_W + COEF_W + K_W;

    localparam logic [K_W-1:0]          K_LAST  = K_W'(N_TAPS - 1);
    localparam logic signed [ACC_W:0]   RND_ADD = (ACC_W + 1)'((2 ** SHIFT) / 2);
    localparam logic signed [ACC_W:0]   OUT_MAX = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0]   OUT_MIN = -OUT_MAX - (ACC_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StMac, StRound, StHold} state_e;

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] x_q [N_TAPS];
    logic signed [DATA_W-1:0] x_d [N_TAPS];
    logic signed [COEF_W-1:0] c_q [N_TAPS];
    logic signed [COEF_W-1:0] c_d [N_TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [K_W-1:0]           k_q, k_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    acc_rnd;
    logic signed [ACC_W:0]    acc_shr;
    logic signed [OUT_W-1:0]  sat;
    logic                     addr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (k_q == K_LAST) state_d = StRound;
            StRound: state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q == StMac) || (state_q == StRound);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        prod    = x_q[k_q] * c_q[k_q];
        acc_rnd = {acc_q[ACC_W-1], acc_q} + RND_ADD;
        acc_shr = acc_rnd >>> SHIFT;
        if (acc_shr > OUT_MAX) begin
            sat = OUT_MAX[OUT_W-1:0];
        end else if (acc_shr < OUT_MIN) begin
            sat = OUT_MIN[OUT_W-1:0];
        end else begin
            sat = acc_shr[OUT_W-1:0];
        end
        // Zero-extend so non-power-of-two tap counts reject the unused addresses
        addr_ok = ({{(32 - K_W){1'b0}}, coef_addr} < N_TAPS);
    end

    // Datapath next-state
    always_comb begin
        x_d         = x_q;
        c_d         = c_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (coef_we && (state_q == StIdle) && addr_ok) begin
            c_d[coef_addr] = coef_wdata;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    for (int i = N_TAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0] = in_data;
                    acc_d  = '0;
                    k_d    = '0;
                end
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + K_W'(1);
            end
            StRound: begin
                out_data_d  = sat;
                out_valid_d = 1'b1;
            end
            StHold: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
            acc_q       <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_filter_seq.sv
// Self-checking bench for fir_filter_seq: two instances (SHIFT=0 and SHIFT=2) share stimulus
// and are compared against a plain-arithmetic convolution model.
module tb_fir_filter_seq;

    localparam int N  = 8;
    localparam int OW = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [8:0] in_data;
    logic              in_valid;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic signed [8:0] coef_wdata;
    logic              out_ready;

    logic              in_ready0, in_ready2;
    logic signed [8:0] out_data0, out_data2;
    logic              out_valid0, out_valid2;
    logic              busy0, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    int c_m [N];
    int x_m [N];

    always #5 clk = ~clk;

    fir_filter_seq #(
        .DATA_W(9), .COEF_W(9), .N_TAPS(N), .OUT_W(OW), .SHIFT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .busy(busy0)
    );

    fir_filter_seq #(
        .DATA_W(9), .COEF_W(9), .N_TAPS(N), .OUT_W(OW), .SHIFT(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready), .busy(busy2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd_val();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N; k++) begin
            c_m[k] = 0;
            x_m[k] = 0;
        end
    endfunction

    function automatic void shift_in(input int v);
        for (int k = N - 1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = v;
    endfunction

    // Convolution, then floor((y + d/2) / d), then clamp to the output range
    function automatic int predict(input int s);
        int y, d, num, q, lo, hi;
        y = 0;
        for (int k = 0; k < N; k++) y += c_m[k] * x_m[k];
        d   = 1 << s;
        num = y + d / 2;
        q   = num / d;
        if ((num % d != 0) && (num < 0)) q = q - 1;
        hi = (1 << (OW - 1)) - 1;
        lo = -(1 << (OW - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    task automatic write_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = 3'(a);
        coef_wdata = 9'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
        c_m[a] = v;
    endtask

    task automatic run_sample(input int v, input int hold, input bit mac_we, input bit mac_rst);
        int n, lat, e0, e2;
        bit seen;
        in_data  = 9'(v);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", int'(in_ready0), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        shift_in(v);
        chk("busy_mac", int'(busy0), 1);
        chk("ready_mac", int'(in_ready0), 0);

        if (mac_rst) begin
            @(posedge clk);
            @(posedge clk);
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            model_clear();
            seen = 1'b0;
            repeat (20) begin
                @(posedge clk); #1;
                seen = seen | out_valid0 | out_valid2;
            end
            chk("rst_no_out", int'(seen), 0);
            chk("rst_ready", int'(in_ready0), 1);
            return;
        end

        e0 = predict(0);
        e2 = predict(2);
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            coef_we = 1'b0;
            if (mac_we && lat == 2) begin
                coef_we    = 1'b1;
                coef_addr  = 3'd0;
                coef_wdata = 9'sd100;
            end
        end
        coef_we = 1'b0;
        chk("latency", lat, N + 1);
        chk("valid2", int'(out_valid2), 1);
        chk("data0", int'(out_data0), e0);
        chk("data2", int'(out_data2), e2);

        if (hold > 0) begin
            // Offer junk input while stalled; it must be ignored
            in_valid = 1'b1;
            in_data  = 9'(rnd_val());
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_data", int'(out_data0), e0);
                chk("hold_valid", int'(out_valid0), 1);
                chk("hold_ready", int'(in_ready0), 0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", int'(out_valid0), 0);
        chk("post_ready", int'(in_ready0), 1);
    endtask

    task automatic stream(input int cnt);
        int q0[$];
        int q2[$];
        int sent, got, cyc, last;
        bit acc_now;
        sent = 0; got = 0; cyc = 0; last = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 9'(rnd_val());
        while (got < cnt && cyc < 100 * cnt) begin
            acc_now = in_ready0 && in_valid;
            if (out_valid0) begin
                if (q0.size() > 0) begin
                    chk("stream_d0", int'(out_data0), q0.pop_front());
                    chk("stream_d2", int'(out_data2), q2.pop_front());
                    got++;
                end else begin
                    chk("stream_spurious", int'(out_valid0), 0);
                end
            end
            if (acc_now) begin
                shift_in(int'(in_data));
                q0.push_back(predict(0));
                q2.push_back(predict(2));
                if (last >= 0) chk("stream_gap", cyc - last, N + 3);
                last = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (sent < cnt) in_data = 9'(rnd_val());
                else in_valid = 1'b0;
            end
        end
        chk("stream_count", got, cnt);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_wdata = '0; out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid0), 0);
        chk("rst_data", int'(out_data0), 0);
        chk("rst_busy", int'(busy0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(in_ready0), 1);

        // Impulse response with c[k] = k+1
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        run_sample(1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) run_sample(0, 0, 1'b0, 1'b0);

        // Saturation, both polarities
        for (int k = 0; k < N; k++) write_coef(k, 255);
        for (int i = 0; i < 8; i++) run_sample(255, 0, 1'b0, 1'b0);
        chk("sat_pos", int'(out_data0), 255);
        for (int i = 0; i < 8; i++) run_sample(-256, 0, 1'b0, 1'b0);
        chk("sat_neg", int'(out_data0), -256);

        // Rounding on the SHIFT=2 instance
        write_coef(0, 1);
        for (int k = 1; k < N; k++) write_coef(k, 0);
        run_sample(5, 0, 1'b0, 1'b0);
        run_sample(6, 0, 1'b0, 1'b0);
        run_sample(-6, 0, 1'b0, 1'b0);
        chk("round_neg", int'(out_data2), -1);

        // Backpressure with random coefficients
        for (int k = 0; k < N; k++) write_coef(k, rnd_val());
        run_sample(rnd_val(), 20, 1'b0, 1'b0);
        run_sample(rnd_val(), 0, 1'b0, 1'b0);

        // Coefficient write during MAC must be dropped
        write_coef(0, 33);
        run_sample(rnd_val(), 0, 1'b1, 1'b0);
        run_sample(1, 0, 1'b0, 1'b0);

        // Back-to-back streaming with random data
        stream(5);

        // Mid-operation reset clears coefficients
        run_sample(rnd_val(), 0, 1'b0, 1'b1);
        run_sample(1, 0, 1'b0, 1'b0);
        chk("post_rst_zero", int'(out_data0), 0);
        run_sample(rnd_val(), 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
